// File: rtl/store_drain_buffer.sv
// ============================================================================
// Module   : store_drain_buffer
// Purpose  : Accepts one core store per clock into a FIFO and drains the
//            entries in order to a slower downstream bus over req/ack.
//            Optional macro STORE_COALESCE_EN merges repeat stores into the tail.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_drain_buffer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_data,
  input  logic                     mem_we,
  output logic                     bus_req,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_data,
  input  logic                     bus_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int             PW         = $clog2(DEPTH);
  localparam int             CW         = PW + 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic hit;
  logic pop;
  logic push;
  logic drop;
  logic coalesce;

  assign hit = mem_we && ((mem_addr & ADDR_MASK) == ADDR_BASE);
  assign pop = bus_req && bus_ack;

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - PW'(1);
  // With a single entry the tail is the head being presented, so it must not change.
  assign coalesce = hit && (count_r >= CW'(2)) && (addr_mem[tail_ptr] == mem_addr);
`else
  assign coalesce = 1'b0;
`endif

  assign push = hit && !coalesce && (!full || pop);
  assign drop = hit && !coalesce && full && !pop;

  // Storage carries no reset; validity is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= mem_addr;
      data_mem[wr_ptr] <= mem_data;
    end
`ifdef STORE_COALESCE_EN
    else if (coalesce) begin
      data_mem[tail_ptr] <= mem_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (drop) overflow_r <= 1'b1;
    end
  end

  assign bus_req  = (count_r != '0);
  assign bus_addr = addr_mem[rd_ptr];
  assign bus_data = data_mem[rd_ptr];
  assign count    = count_r;
  assign full     = (count_r == FULL_COUNT);
  assign overflow = overflow_r;

endmodule

`default_nettype wire
